// File: rtl/pile_manager.sv
// pile_manager: three-column brick pile tracker with row-clear scoring, game FSM
// and an LFSR-driven choice of the next brick column.
module pile_manager #(
    parameter int         MAX_HEIGHT = 5,
    parameter int         SCORE_W    = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               plus_left,
    input  logic               plus_center,
    input  logic               plus_right,
    input  logic               aligned,
    input  logic               lost,
    output logic [2:0]         height_left,
    output logic [2:0]         height_center,
    output logic [2:0]         height_right,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state,
    output logic [1:0]         next_col,
    output logic               game_over
);
    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, CLEAR = 2'b10, OVER = 2'b11} state_t;

    state_t             st, st_n;
    logic [7:0]         lfsr;
    logic [2:0]         hl_n, hc_n, hr_n;
    logic [SCORE_W-1:0] score_n;
    logic [1:0]         col_n;
    logic               active, clr, zero, any_plus;

    // Clear decrement is applied before the landing brick, then saturate.
    function automatic logic [2:0] bump(input logic [2:0] h, input logic dec, input logic inc);
        logic [2:0] d;
        d = h - {2'b00, dec};
        return (inc && d < 3'(MAX_HEIGHT)) ? d + 3'd1 : d;
    endfunction

    always_comb begin
        active   = (st == PLAY || st == CLEAR) && !lost;
        clr      = st == PLAY && !lost && aligned &&
                   height_left != 3'd0 && height_center != 3'd0 && height_right != 3'd0;
        zero     = st == OVER && start;
        any_plus = active && (plus_left || plus_center || plus_right);
        st_n     = st == IDLE ? (start ? PLAY : IDLE) :
                   st == OVER ? (start ? PLAY : OVER) :
                   lost       ? OVER :
                   clr        ? CLEAR : PLAY;
        hl_n     = zero ? 3'd0 : active ? bump(height_left, clr, plus_left) : height_left;
        hc_n     = zero ? 3'd0 : active ? bump(height_center, clr, plus_center) : height_center;
        hr_n     = zero ? 3'd0 : active ? bump(height_right, clr, plus_right) : height_right;
        score_n  = zero ? '0 : (clr && score != '1) ? score + 1'b1 : score;
        col_n    = any_plus ? (lfsr[1:0] == 2'b11 ? 2'b01 : lfsr[1:0]) : next_col;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= IDLE;
            lfsr          <= LFSR_SEED;
            height_left   <= 3'd0;
            height_center <= 3'd0;
            height_right  <= 3'd0;
            score         <= '0;
            next_col      <= 2'b01;
            game_over     <= 1'b0;
        end else begin
            st            <= st_n;
            lfsr          <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            height_left   <= hl_n;
            height_center <= hc_n;
            height_right  <= hr_n;
            score         <= score_n;
            next_col      <= col_n;
            game_over     <= st_n == OVER;
        end
    end

    assign state = st;
endmodule

// File: tb/tb_pile_manager.sv
// tb_pile_manager: directed checks of the pile manager with a reference LFSR model.
module tb_pile_manager;
    logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic       plus_left = 1'b0, plus_center = 1'b0, plus_right = 1'b0;
    logic       aligned = 1'b0, lost = 1'b0;
    logic [2:0] height_left, height_center, height_right;
    logic [7:0] score;
    logic [1:0] state, next_col;
    logic       game_over;
    logic [7:0] m_lfsr;
    logic [1:0] exp_col;
    int         checks = 0, errors = 0;

    pile_manager dut (
        .clk(clk), .reset(reset), .start(start),
        .plus_left(plus_left), .plus_center(plus_center), .plus_right(plus_right),
        .aligned(aligned), .lost(lost),
        .height_left(height_left), .height_center(height_center), .height_right(height_right),
        .score(score), .state(state), .next_col(next_col), .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        m_lfsr <= reset ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_h(input string tag, input logic [2:0] l, input logic [2:0] c, input logic [2:0] r);
        check(tag, {height_left, height_center, height_right}, {l, c, r});
    endtask

    task automatic set_plus(input logic [2:0] p);
        {plus_left, plus_center, plus_right} = p;
    endtask

    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", state, 2'b00);
        check_h("rst_heights", 3'd0, 3'd0, 3'd0);
        check("rst_score", score, 8'd0);
        check("rst_next_col", next_col, 2'b01);
        check("rst_game_over", game_over, 1'b0);
        check("rst_lfsr", dut.lfsr, 8'hA5);

        set_plus(3'b111); aligned = 1'b1; lost = 1'b1;
        tick();
        set_plus(3'b000); aligned = 1'b0; lost = 1'b0;
        check("idle_state", state, 2'b00);
        check_h("idle_heights", 3'd0, 3'd0, 3'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_play", state, 2'b01);
        for (int i = 0; i < 3; i++) begin
            set_plus(3'b100);
            tick();
        end
        set_plus(3'b000);
        check_h("left_x3", 3'd3, 3'd0, 3'd0);
        check("left_x3_score", score, 8'd0);

        restart();
        set_plus(3'b111);
        tick();
        check_h("simul_plus", 3'd1, 3'd1, 3'd1);
        set_plus(3'b010);
        tick();
        check_h("h_121", 3'd1, 3'd2, 3'd1);
        aligned = 1'b1;
        tick();
        set_plus(3'b000); aligned = 1'b0;
        check_h("clear_heights", 3'd0, 3'd2, 3'd0);
        check("clear_score", score, 8'd1);
        check("clear_state", state, 2'b10);
        tick();
        check("clear_back_play", state, 2'b01);
        check_h("clear_after", 3'd0, 3'd2, 3'd0);

        set_plus(3'b001);
        tick();
        set_plus(3'b000);
        aligned = 1'b1;
        tick();
        aligned = 1'b0;
        check_h("unqual_heights", 3'd0, 3'd2, 3'd1);
        check("unqual_score", score, 8'd1);
        check("unqual_state", state, 2'b01);

        for (int i = 0; i < 5; i++) begin
            set_plus(3'b001);
            tick();
        end
        set_plus(3'b000);
        check("sat_right", height_right, 3'd5);
        lost = 1'b1; aligned = 1'b1; set_plus(3'b110);
        tick();
        lost = 1'b0; aligned = 1'b0; set_plus(3'b000);
        check("lost_state", state, 2'b11);
        check("lost_game_over", game_over, 1'b1);
        check_h("lost_heights", 3'd0, 3'd2, 3'd5);
        check("lost_score", score, 8'd1);
        for (int i = 0; i < 10; i++) begin
            set_plus(3'($urandom_range(0, 7)));
            aligned = 1'($urandom_range(0, 1));
            tick();
        end
        set_plus(3'b000); aligned = 1'b0;
        check("over_state", state, 2'b11);
        check_h("over_frozen", 3'd0, 3'd2, 3'd5);
        check("over_score", score, 8'd1);

        restart();
        for (int i = 0; i < 7; i++) begin
            set_plus(3'b111);
            tick();
            set_plus(3'b000);
            aligned = 1'b1;
            tick();
            aligned = 1'b0;
            tick();
        end
        check("score7", score, 8'd7);
        lost = 1'b1;
        tick();
        lost = 1'b0;
        check("over7_state", state, 2'b11);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_state", state, 2'b01);
        check_h("restart_heights", 3'd0, 3'd0, 3'd0);
        check("restart_score", score, 8'd0);
        check("restart_game_over", game_over, 1'b0);

        set_plus(3'b111);
        tick();
        set_plus(3'b000);
        aligned = 1'b1;
        tick();
        aligned = 1'b1;
        set_plus(3'b100);
        tick();
        aligned = 1'b0; set_plus(3'b000);
        check("clear_ignores_aligned", score, 8'd1);
        check_h("clear_applies_plus", 3'd1, 3'd0, 3'd0);
        set_plus(3'b111);
        tick();
        set_plus(3'b000);
        aligned = 1'b1;
        tick();
        aligned = 1'b0;
        check("pre_rst_clear", state, 2'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midclear_rst_state", state, 2'b00);
        check("midclear_rst_score", score, 8'd0);
        check_h("midclear_rst_heights", 3'd0, 3'd0, 3'd0);

        restart();
        exp_col = 2'b01;
        for (int i = 0; i < 1000; i++) begin
            set_plus(3'($urandom_range(0, 7)));
            if (plus_left || plus_center || plus_right)
                exp_col = m_lfsr[1:0] == 2'b11 ? 2'b01 : m_lfsr[1:0];
            tick();
            check("col_model", next_col, exp_col);
            check("col_not_11", next_col != 2'b11, 1'b1);
            check("lfsr_model", dut.lfsr, m_lfsr);
        end
        set_plus(3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
